// File: rtl/move_pkg.sv
// Shared encodings for the move undo/replay block: move codes, game phases, FSM states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. The REPLAY states exist only when MOVE_UNDO_REPLAY_EN is defined.
package move_pkg;

    typedef enum logic [1:0] {
        MV_UP    = 2'd0,
        MV_DOWN  = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_e;

    typedef enum logic [1:0] {
        GS_CHOSE_BOARD  = 2'b00,
        GS_GAMING       = 2'b01,
        GS_GAME_INITIAL = 2'b10,
        GS_WINNED       = 2'b11
    } game_status_e;

`ifdef MOVE_UNDO_REPLAY_EN
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_UNDO_EMIT   = 2'd1,
        ST_REPLAY_EMIT = 2'd2,
        ST_REPLAY_WAIT = 2'd3
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_UNDO_EMIT = 1'b1
    } state_e;
`endif

    // Opposite direction: up<->down, left<->right.
    function automatic logic [1:0] inv_move(input logic [1:0] mv);
        logic [1:0] r;
        case (mv)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd0;
            2'd2:    r = 2'd3;
            default: r = 2'd2;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] move_onehot(input logic [1:0] mv);
        return 4'b0001 << mv;
    endfunction

    // Only meaningful for one-hot input; callers qualify with is_onehot first.
    function automatic logic [1:0] onehot_move(input logic [3:0] oh);
        logic [1:0] r;
        case (oh)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/move_stack.sv
// Circular LIFO of 2-bit move codes; a push at full overwrites the oldest entry.
// Latency: push/pop/clear take effect on the next rising edge; top_o is combinational from state.
// Backpressure: none; pop on empty is ignored, count saturates at DEPTH.
module move_stack #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [1:0]               push_dat_i,
    input  logic                     pop_i,
    output logic [1:0]               top_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] top_ptr;
    logic [CW-1:0] cnt_q, cnt_d;

    // Write pointer wraps naturally, so the ring overwrites the oldest slot once full.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (pop_i && (cnt_q != '0)) begin
            wr_ptr_d = wr_ptr_q - PW'(1);
            cnt_d    = cnt_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage holds data only; validity is tracked by cnt_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign top_ptr = wr_ptr_q - PW'(1);
    assign top_o   = mem_q[top_ptr];
    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/move_undo.sv
// Records player moves and emits inverse moves for single-step undo or full replay (MOVE_UNDO_REPLAY_EN).
// Latency: undo_act pulses one cycle after a valid undo/replay request; replay pulses every GAP+1 cycles.
// Backpressure: none; requests arriving while busy, empty, or outside GAMING are dropped.
module move_undo #(
    parameter int DEPTH = 16,
    parameter int GAP   = 4
) (
    input  logic                   clk_d,
    input  logic                   rst_n,
    input  logic [3:0]             act_flag,
    input  logic [1:0]             game_status,
    input  logic                   undo_flag,
    input  logic                   replay_flag,
    output logic [3:0]             undo_act,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] move_cnt,
    output logic                   empty,
    output logic                   full
);
    import move_pkg::*;

    state_e     state_q, state_d;
    logic [3:0] undo_act_q, undo_act_d;
    logic       st_gaming, st_clear, rec_vld;
    logic       push, pop;
    logic [1:0] top_mv;
    logic [3:0] top_inv_oh;
    logic       stk_empty;

`ifdef MOVE_UNDO_REPLAY_EN
    localparam int WW = (GAP > 1) ? $clog2(GAP) : 1;
    logic          busy_q, busy_d;
    logic [WW-1:0] wait_q, wait_d;
`else
    logic unused_replay;
    assign unused_replay = replay_flag | (GAP == 0);
`endif

    assign st_gaming  = (game_status == GS_GAMING);
    assign st_clear   = (game_status == GS_GAME_INITIAL) || (game_status == GS_CHOSE_BOARD);
    assign rec_vld    = is_onehot(act_flag);
    assign top_inv_oh = move_onehot(inv_move(top_mv));

    move_stack #(.DEPTH(DEPTH)) u_stack (
        .clk_i      (clk_d),
        .rst_n      (rst_n),
        .clr_i      (st_clear),
        .push_i     (push),
        .push_dat_i (onehot_move(act_flag)),
        .pop_i      (pop),
        .top_o      (top_mv),
        .cnt_o      (move_cnt),
        .empty_o    (stk_empty),
        .full_o     (full)
    );

    // Next-state: a player move outranks undo, undo outranks replay; leaving GAMING aborts to IDLE.
    always_comb begin
        state_d    = state_q;
        undo_act_d = 4'b0000;
        push       = 1'b0;
        pop        = 1'b0;
`ifdef MOVE_UNDO_REPLAY_EN
        busy_d     = 1'b0;
        wait_d     = wait_q;
`endif
        if (!st_gaming) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rec_vld) begin
                        push = 1'b1;
                    end else if (undo_flag && !stk_empty) begin
                        pop        = 1'b1;
                        undo_act_d = top_inv_oh;
                        state_d    = ST_UNDO_EMIT;
                    end
`ifdef MOVE_UNDO_REPLAY_EN
                    else if (replay_flag && !stk_empty) begin
                        pop        = 1'b1;
                        undo_act_d = top_inv_oh;
                        busy_d     = 1'b1;
                        state_d    = ST_REPLAY_EMIT;
                    end
`endif
                end
                ST_UNDO_EMIT: state_d = ST_IDLE;
`ifdef MOVE_UNDO_REPLAY_EN
                ST_REPLAY_EMIT: begin
                    busy_d  = 1'b1;
                    wait_d  = '0;
                    state_d = ST_REPLAY_WAIT;
                end
                ST_REPLAY_WAIT: begin
                    busy_d = 1'b1;
                    if (wait_q == WW'(GAP - 1)) begin
                        if (!stk_empty) begin
                            pop        = 1'b1;
                            undo_act_d = top_inv_oh;
                            state_d    = ST_REPLAY_EMIT;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            undo_act_q <= 4'b0000;
`ifdef MOVE_UNDO_REPLAY_EN
            busy_q     <= 1'b0;
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            undo_act_q <= undo_act_d;
`ifdef MOVE_UNDO_REPLAY_EN
            busy_q     <= busy_d;
            wait_q     <= wait_d;
`endif
        end
    end

    assign undo_act = undo_act_q;
    assign empty    = stk_empty;
`ifdef MOVE_UNDO_REPLAY_EN
    assign busy     = busy_q;
`else
    assign busy     = 1'b0;
`endif

endmodule

// File: tb/tb_move_undo.sv
// Directed bench for move_undo: recording, undo, overwrite-at-full, status handling, replay/abort.
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_move_undo;
    import move_pkg::*;

    localparam int DEPTH = 16;
    localparam int GAP   = 4;

    logic       clk_d = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] act_flag = 4'b0;
    logic [1:0] game_status = 2'b00;
    logic       undo_flag = 1'b0;
    logic       replay_flag = 1'b0;
    logic [3:0] undo_act;
    logic       busy;
    logic [4:0] move_cnt;
    logic       empty, full;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] inv_oh [4];
    logic [1:0] seq [20];

    move_undo #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_d       (clk_d),
        .rst_n       (rst_n),
        .act_flag    (act_flag),
        .game_status (game_status),
        .undo_flag   (undo_flag),
        .replay_flag (replay_flag),
        .undo_act    (undo_act),
        .busy        (busy),
        .move_cnt    (move_cnt),
        .empty       (empty),
        .full        (full)
    );

    always #5 clk_d = ~clk_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_d);
        #1;
    endtask

    task automatic do_move(input logic [1:0] mv);
        act_flag = 4'b0001 << mv;
        step();
        act_flag = 4'b0000;
    endtask

    task automatic clear_stack();
        game_status = GS_GAME_INITIAL;
        step();
        game_status = GS_GAMING;
    endtask

    initial begin : main
        logic [3:0] acc_act;
        logic       acc_busy;
        logic [3:0] exp_act;
        logic       exp_busy;

        inv_oh[0] = 4'b0010;   // up    -> down
        inv_oh[1] = 4'b0001;   // down  -> up
        inv_oh[2] = 4'b1000;   // left  -> right
        inv_oh[3] = 4'b0100;   // right -> left
        for (int i = 0; i < 20; i++) seq[i] = 2'((i * 3 + i / 4) % 4);

        // Reset state, checked while reset is still asserted
        #2;
        check("rst_undo_act", undo_act, 0);
        check("rst_busy", busy, 0);
        check("rst_move_cnt", move_cnt, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        #10;
        rst_n = 1'b1;
        game_status = GS_GAMING;
        step();

        // up, left, right then undo -> left pulse for one cycle
        do_move(2'd0);
        do_move(2'd2);
        do_move(2'd3);
        check("three_moves_cnt", move_cnt, 3);
        undo_flag = 1'b1;
        step();
        undo_flag = 1'b0;
        check("undo_pulse_left", undo_act, 4'b0100);
        check("undo_cnt_dec", move_cnt, 2);
        step();
        check("undo_pulse_one_cycle", undo_act, 0);

        // Clear via GAME_INITIAL
        clear_stack();
        check("clear_cnt", move_cnt, 0);
        check("clear_empty", empty, 1);

        // 20 moves into a 16-deep stack, then 17 undos
        for (int i = 0; i < 20; i++) do_move(seq[i]);
        check("full_flag", full, 1);
        check("full_cnt_sat", move_cnt, 16);
        for (int k = 0; k < 16; k++) begin
            undo_flag = 1'b1;
            step();
            undo_flag = 1'b0;
            check($sformatf("undo_seq_%0d", k), undo_act, inv_oh[seq[19 - k]]);
            step();
            check($sformatf("undo_gap_%0d", k), undo_act, 0);
        end
        check("drain_empty", empty, 1);
        check("drain_cnt", move_cnt, 0);
        undo_flag = 1'b1;
        step();
        undo_flag = 1'b0;
        check("undo_on_empty", undo_act, 0);

        // Simultaneous move and undo: move wins
        do_move(2'd1);
        act_flag  = 4'b0001;
        undo_flag = 1'b1;
        step();
        act_flag  = 4'b0000;
        undo_flag = 1'b0;
        check("act_undo_same_cnt", move_cnt, 2);
        check("act_undo_same_act", undo_act, 0);

        // Multi-hot and zero-hot ignored
        act_flag = 4'b0011;
        step();
        act_flag = 4'b0000;
        step();
        check("multihot_ignored", move_cnt, 2);

        // WINNED freezes the stack
        game_status = GS_WINNED;
        do_move(2'd2);
        undo_flag = 1'b1;
        step();
        undo_flag = 1'b0;
        check("winned_undo_act", undo_act, 0);
        check("winned_cnt_frozen", move_cnt, 2);
        game_status = GS_GAMING;

`ifdef MOVE_UNDO_REPLAY_EN
        // Full replay: pulses at cycles 0, 5, 10; busy through cycle 14
        clear_stack();
        do_move(2'd0);
        do_move(2'd2);
        do_move(2'd3);
        replay_flag = 1'b1;
        step();
        replay_flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            case (c)
                0:       exp_act = 4'b0100;
                5:       exp_act = 4'b1000;
                10:      exp_act = 4'b0010;
                default: exp_act = 4'b0000;
            endcase
            exp_busy = (c < 15);
            check($sformatf("replay_c%0d", c), {busy, undo_act}, {exp_busy, exp_act});
            act_flag  = (c == 2) ? 4'b0001 : 4'b0000;
            undo_flag = (c == 7);
            step();
        end
        act_flag  = 4'b0000;
        undo_flag = 1'b0;
        check("replay_end_empty", empty, 1);
        check("replay_end_cnt", move_cnt, 0);

        // Abort by GAME_INITIAL mid-replay
        do_move(2'd0);
        do_move(2'd1);
        do_move(2'd2);
        replay_flag = 1'b1;
        step();
        replay_flag = 1'b0;
        step();
        step();
        step();
        game_status = GS_GAME_INITIAL;
        step();
        check("abort_init_cnt", move_cnt, 0);
        check("abort_init_busy", busy, 0);
        game_status = GS_GAMING;
        acc_act  = 4'b0000;
        acc_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            acc_act  = acc_act | undo_act;
            acc_busy = acc_busy | busy;
            step();
        end
        check("abort_init_no_pulses", {acc_busy, acc_act}, 0);

        // Abort by reset mid-replay
        do_move(2'd3);
        do_move(2'd3);
        do_move(2'd1);
        replay_flag = 1'b1;
        step();
        replay_flag = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_rst_cnt", move_cnt, 0);
        check("abort_rst_busy", busy, 0);
        check("abort_rst_act", undo_act, 0);
        #1;
        rst_n = 1'b1;
        acc_act  = 4'b0000;
        acc_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            acc_act  = acc_act | undo_act;
            acc_busy = acc_busy | busy;
        end
        check("abort_rst_no_pulses", {acc_busy, acc_act}, 0);
`else
        // Replay disabled: replay_flag must do nothing
        clear_stack();
        do_move(2'd0);
        do_move(2'd2);
        replay_flag = 1'b1;
        step();
        replay_flag = 1'b0;
        acc_act  = undo_act;
        acc_busy = busy;
        for (int c = 0; c < 12; c++) begin
            step();
            acc_act  = acc_act | undo_act;
            acc_busy = acc_busy | busy;
        end
        check("norep_no_pulse", acc_act, 0);
        check("norep_busy", acc_busy, 0);
        check("norep_cnt", move_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/move_undo.md
MOVE_UNDO -- requirements
Module: move_undo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, setting the number of recorded moves (power of two, 4..64).
REQ-002 The block SHALL have parameter GAP, default 4, setting the idle cycles between replayed moves.
REQ-003 Port clk_d  input  1  is the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port act_flag  input  4  carries one-cycle player move pulses, one-hot: [0] up, [1] down, [2] left, [3] right.
REQ-006 Port game_status  input  2  carries the game phase: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
REQ-007 Port undo_flag  input  1  is a one-cycle request to undo the last move.
REQ-008 Port replay_flag  input  1  is a one-cycle request to rewind all recorded moves.
REQ-009 Port undo_act  output  4  carries the one-cycle inverse move pulse, one-hot, same bit map as act_flag; it is ORed into the game's act path.
REQ-010 Port busy  output  1  is high while a replay is in progress.
REQ-011 Port move_cnt  output  clog2(DEPTH)+1  gives the number of stored moves.
REQ-012 Ports empty and full  output  1 each  give the stack state.

Function
REQ-013 A move SHALL be recorded only in state IDLE, with game_status==GAMING and act_flag exactly one-hot.
- Zero-hot or multi-hot act_flag is ignored.
REQ-014 Moves SHALL be stored as 2-bit codes in a circular LIFO.
- At full, a new move overwrites the oldest entry.
- move_cnt saturates at DEPTH.
REQ-015 The inverse move map SHALL be: up<->down, left<->right.
REQ-016 Undo latency: undo_flag at cycle n in IDLE with !empty SHALL give the inverse of the top move on undo_act at cycle n+1 for exactly one cycle.
- move_cnt is decremented at the same edge.
REQ-017 An undo_flag while empty, while busy, or outside GAMING SHALL be ignored, and undo_act stays 0.
REQ-018 If act_flag and undo_flag arrive in the same cycle, the player move SHALL be recorded and the undo SHALL be dropped.
REQ-019 Moves emitted on undo_act SHALL never be recorded.
REQ-020 The FSM SHALL have four states with these transitions:
- IDLE -> UNDO_EMIT on a valid undo; UNDO_EMIT -> IDLE after 1 cycle.
- IDLE -> REPLAY_EMIT on replay_flag with !empty in GAMING.
- REPLAY_EMIT (1 cycle, one pop) -> REPLAY_WAIT; REPLAY_WAIT (GAP cycles) -> REPLAY_EMIT while !empty, else -> IDLE.
REQ-021 busy SHALL be high in REPLAY_EMIT and REPLAY_WAIT; player acts and undo_flag are ignored and not recorded while busy.
REQ-022 When game_status enters GAME_INITIAL or CHOSE_BOARD, the stack SHALL clear on the next edge, from any state.
- The FSM returns to IDLE.
- No further undo_act pulses are emitted.
REQ-023 The transition to WINNED SHALL freeze the stack; no recording, undo or replay takes place until the next clear.

Reset
REQ-024 On rst_n low, the block SHALL immediately set: state IDLE, undo_act 0, busy 0, move_cnt 0, empty 1, full 0, pointers 0.
REQ-025 A reset during a replay SHALL abort it with no further pulses after release.

Configuration
REQ-026 With MOVE_UNDO_REPLAY_EN defined, the block SHALL implement replay_flag, busy and the REPLAY states.
REQ-027 Without MOVE_UNDO_REPLAY_EN, the block SHALL ignore replay_flag, tie busy to 0 and omit the REPLAY states; single-step undo is unaffected.

Structure
REQ-028 Package move_pkg SHALL hold:
- the move codes (UP=0, DOWN=1, LEFT=2, RIGHT=3);
- the game_status encodings;
- the FSM state encoding;
- the inverse-move function.
REQ-029 A sub-module move_stack SHALL implement the circular LIFO: push, pop, count, overwrite-at-full.

Verification
REQ-030 Scenario: GAMING, moves up, left, right; then undo_flag -> undo_act=4'b0100 (left) one cycle later for 1 cycle; move_cnt 3->2.
REQ-031 Scenario: 20 moves with DEPTH=16 -> full=1, move_cnt=16; 16 undos return the inverses of moves 20..5 in order; the 17th undo gives undo_act=0 and empty=1.
REQ-032 Scenario: act_flag=0001 and undo_flag in the same cycle -> move recorded (cnt+1), undo_act stays 0.
REQ-033 Scenario: 3 moves recorded, then replay_flag -> 3 pulses spaced GAP+1=5 cycles, busy high throughout, then IDLE with empty=1; act_flag during replay is not recorded.
REQ-034 Scenario: replay in progress, game_status goes to GAME_INITIAL -> next edge gives move_cnt=0 and busy=0, with no further pulses; a repeat run with rst_n pulsed low mid-replay gives the same result.
REQ-035 Scenario: build without MOVE_UNDO_REPLAY_EN, replay_flag pulsed -> no undo_act, busy=0, move_cnt unchanged.
